// File: rtl/dmem_initiator.sv
`default_nettype none
// ============================================================================
// dmem_initiator : single-outstanding load/store initiator for the stalling
//                  data-memory port (valid/ready request and response channels)
// Revision       : 1.0
// ============================================================================
module dmem_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  output logic        busy
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we;
  logic               r_out_of_reset;
  logic               w_accept;
  logic               w_misaligned;
  logic               w_timeout;
  logic [3:0]         w_mask;

  // Blocks acceptance during reset and while the memory is still finishing a
  // transaction that a reset interrupted.
  assign req_ready    = (r_state == S_IDLE) & ~mem_stall & r_out_of_reset;
  assign w_accept     = req_valid & req_ready;
  assign w_timeout    = (r_cnt == c_cnt_last);
  assign w_misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  always_comb begin
    w_mask = 4'b0000;
    case (req_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b0111;
      default: w_mask = 4'b0000;
    endcase
    if (~req_we & ~req_unsigned & ~req_size[1])
      w_mask[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_out_of_reset <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_RESP);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_misaligned ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_read  = ~r_we;
        mem_write = r_we;
        w_next    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (mem_stall)
          w_next = S_WAIT_DONE;
        else if (w_timeout)
          w_next = S_RESP;
      end
      S_WAIT_DONE: begin
        if (!mem_stall || w_timeout)
          w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state != w_next)
      r_cnt <= '0;
    else if (r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_sign_mask <= '0;
      r_we          <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            mem_addr      <= req_addr;
            mem_wdata     <= req_wdata;
            mem_sign_mask <= w_mask;
            r_we          <= req_we;
            rsp_rdata     <= '0;
            rsp_err       <= w_misaligned ? 2'b01 : 2'b00;
          end
        end
        S_WAIT_ACK: begin
          if (!mem_stall && w_timeout)
            rsp_err <= 2'b10;
        end
        S_WAIT_DONE: begin
          // Memory has already extended the data; pass it through untouched.
          if (!mem_stall)
            rsp_rdata <= r_we ? '0 : mem_rdata;
          else if (w_timeout)
            rsp_err <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dmem_initiator : randomized and directed checks of dmem_initiator against
//                     a behavioural byte-memory reference model
// Revision          : 1.0
// ============================================================================
module tb_dmem_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata = '0;
  logic        mem_stall = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_read  = 0;
  int n_write = 0;
  int stall_len = 2;
  bit no_ack = 1'b0;

  byte unsigned dm_b  [bit [31:0]];
  byte unsigned ref_b [bit [31:0]];

  always #5 clk = ~clk;

  dmem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_sign_mask(mem_sign_mask),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .busy(busy)
  );

  function automatic logic [7:0] dm_rd(input logic [31:0] a);
    return dm_b.exists(a) ? dm_b[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  // Memory responder: samples the strobe, stalls stall_len cycles, extends loads per mask.
  int          scnt = 0;
  logic [31:0] pend = '0;
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_read)  n_read++;
    if (mem_write) n_write++;
    if ((mem_read || mem_write) && !no_ack) begin
      if (mem_write) begin
        dm_b[mem_addr] = mem_wdata[7:0];
        if (mem_sign_mask[1]) dm_b[mem_addr + 1] = mem_wdata[15:8];
        if (mem_sign_mask[2]) begin
          dm_b[mem_addr + 2] = mem_wdata[23:16];
          dm_b[mem_addr + 3] = mem_wdata[31:24];
        end
        pend = '0;
      end else begin
        w = {dm_rd(mem_addr + 3), dm_rd(mem_addr + 2), dm_rd(mem_addr + 1), dm_rd(mem_addr)};
        if (mem_sign_mask[2])      pend = w;
        else if (mem_sign_mask[1]) pend = mem_sign_mask[3] ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
        else                       pend = mem_sign_mask[3] ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      end
      mem_stall <= 1'b1;
      mem_rdata <= $urandom;
      scnt = stall_len;
    end else if (scnt > 0) begin
      scnt--;
      if (scnt == 0) begin
        mem_stall <= 1'b0;
        mem_rdata <= pend;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] exp_mask(input logic we, input logic [1:0] sz, input logic uns);
    logic [3:0] m;
    m = (sz == 2'd0) ? 4'd1 : (sz == 2'd1) ? 4'd3 : (sz == 2'd2) ? 4'd7 : 4'd0;
    if (!we && !uns && sz < 2'd2) m = m + 4'd8;
    return m;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    ref_b[a] = wd[7:0];
    if (sz >= 2'd1) ref_b[a + 1] = wd[15:8];
    if (sz == 2'd2) begin
      ref_b[a + 2] = wd[23:16];
      ref_b[a + 3] = wd[31:24];
    end
  endtask

  // ---------------- driver (no checking) ----------------
  typedef struct {
    bit          acc;
    int          k;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          nrd;
    int          nwr;
    bit          stable;
    logic        vafter;
  } res_t;

  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input int hold, output res_t r);
    int r0, w0;
    r = '{acc: 1'b0, k: 0, err: 2'bxx, rdata: 'x, mask: 'x, maddr: 'x, mwdata: 'x,
          nrd: 0, nwr: 0, stable: 1'b1, vafter: 1'bx};
    r0 = n_read;
    w0 = n_write;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin r.acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!r.acc) begin req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    r.maddr = mem_addr; r.mwdata = mem_wdata; r.mask = mem_sign_mask;
    while (!rsp_valid && r.k < 40) begin
      @(negedge clk);
      r.k++;
    end
    r.err = rsp_err;
    r.rdata = rsp_rdata;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== r.err || rsp_rdata !== r.rdata) r.stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    r.vafter = rsp_valid;
    r.nrd = n_read - r0;
    r.nwr = n_write - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err, mem_sign_mask} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err, mem_sign_mask});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rsp_rdata});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_directed;
    logic        t_we [5];
    logic [31:0] t_a  [5];
    logic [31:0] t_wd [5];
    logic [1:0]  t_sz [5];
    logic        t_u  [5];
    logic [31:0] t_rd [5];
    logic [3:0]  t_m  [5];
    res_t r;
    t_we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_a  = '{32'h1004, 32'h1003, 32'h1003, 32'h2000, 32'h2000};
    t_wd = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
    t_sz = '{2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
    t_u  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_rd = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h0, 32'h4};
    t_m  = '{4'b0111, 4'b1001, 4'b0001, 4'b0111, 4'b0111};
    stall_len = 2;
    for (int i = 0; i < 5; i++) begin
      run_txn(t_we[i], t_a[i], t_wd[i], t_sz[i], t_u[i], 0, r);
      n_tests++;
      if (!r.acc || r.k != 4 || r.err !== 2'b00) begin
        n_fail++;
        $display("FAIL dir%0d_rsp: got acc=%0d lat=%0d err=%b expected acc=1 lat=4 err=00", i, r.acc, r.k, r.err);
      end
      n_tests++;
      if (r.rdata !== t_rd[i]) begin
        n_fail++;
        $display("FAIL dir%0d_rdata: got %h expected %h", i, r.rdata, t_rd[i]);
      end
      n_tests++;
      if (r.mask !== t_m[i] || r.maddr !== t_a[i] || r.mwdata !== t_wd[i]) begin
        n_fail++;
        $display("FAIL dir%0d_bus: got mask=%b addr=%h wdata=%h expected mask=%b addr=%h wdata=%h",
                 i, r.mask, r.maddr, r.mwdata, t_m[i], t_a[i], t_wd[i]);
      end
      n_tests++;
      if (r.nrd != (t_we[i] ? 0 : 1) || r.nwr != (t_we[i] ? 1 : 0)) begin
        n_fail++;
        $display("FAIL dir%0d_strobe: got reads=%0d writes=%0d expected %0d/%0d", i, r.nrd, r.nwr,
                 t_we[i] ? 0 : 1, t_we[i] ? 1 : 0);
      end
      if (t_we[i]) ref_store(t_a[i], t_wd[i], t_sz[i]);
    end
  endtask

  task automatic test_misaligned;
    logic        t_we [4];
    logic [31:0] t_a  [4];
    logic [1:0]  t_sz [4];
    res_t r;
    t_we = '{1'b0, 1'b0, 1'b0, 1'b1};
    t_a  = '{32'h1001, 32'h1000, 32'h1002, 32'h2003};
    t_sz = '{2'd1, 2'd3, 2'd2, 2'd1};
    for (int i = 0; i < 4; i++) begin
      run_txn(t_we[i], t_a[i], 32'h12345678, t_sz[i], 1'b0, 0, r);
      n_tests++;
      if (!r.acc || r.k > 1 || r.err !== 2'b01 || r.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL mis%0d_rsp: got acc=%0d lat=%0d err=%b rdata=%h expected lat<=1 err=01 rdata=0",
                 i, r.acc, r.k, r.err, r.rdata);
      end
      n_tests++;
      if (r.nrd != 0 || r.nwr != 0) begin
        n_fail++;
        $display("FAIL mis%0d_strobe: got reads=%0d writes=%0d expected 0/0", i, r.nrd, r.nwr);
      end
    end
  endtask

  task automatic test_timeout;
    res_t r;
    no_ack = 1'b1;
    run_txn(1'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 0, r);
    no_ack = 1'b0;
    n_tests++;
    if (r.err !== 2'b10 || r.rdata !== 32'h0 || r.k != TO + 1 || r.nrd != 1) begin
      n_fail++;
      $display("FAIL timeout_ack: got err=%b rdata=%h lat=%0d reads=%0d expected err=10 rdata=0 lat=%0d reads=1",
               r.err, r.rdata, r.k, r.nrd, TO + 1);
    end
    stall_len = 30;
    run_txn(1'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 0, r);
    n_tests++;
    if (r.err !== 2'b10 || r.rdata !== 32'h0 || r.k != TO + 2) begin
      n_fail++;
      $display("FAIL timeout_done: got err=%b rdata=%h lat=%0d expected err=10 rdata=0 lat=%0d",
               r.err, r.rdata, r.k, TO + 2);
    end
    stall_len = 2;
    for (int i = 0; i < 40 && mem_stall; i++) @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: got stall=%b ready=%b expected 0/1", mem_stall, req_ready);
    end
  endtask

  task automatic test_resp_hold;
    res_t r;
    run_txn(1'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 5, r);
    n_tests++;
    if (!r.stable || r.rdata !== 32'hDEADBEEF || r.vafter !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_hold: got stable=%0d rdata=%h valid_after=%b expected 1/deadbeef/0",
               r.stable, r.rdata, r.vafter);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int early;
    stall_len = 12;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1004; req_size = 2'd2; req_unsigned = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (!ok || busy !== 1'b1 || mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got acc=%0d busy=%b stall=%b expected 1/1/1", ok, busy, mem_stall);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err, mem_sign_mask} !== 11'd0 ||
        {mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ctrl=%b addr=%h expected 0/0",
               {req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err, mem_sign_mask}, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 30 && mem_stall; i++) begin
      if (req_ready !== 1'b0) early++;
      @(negedge clk);
    end
    n_tests++;
    if (early != 0 || mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ready_early: got %0d ready cycles, stall=%b expected 0 and 0", early, mem_stall);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready_after: got %b expected 1", req_ready);
    end
    stall_len = 2;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int k;
    ok = 1'b0;
    stall_len = 2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1004; req_size = 2'd2; req_unsigned = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1008; rsp_ready = 1'b1;
    n_tests++;
    if (!ok || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got acc=%0d valid=%b ready=%b expected 1/1/0", ok, rsp_valid, req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got valid=%b busy=%b ready=%b expected 0/0/1", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || mem_addr !== 32'h1008) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b addr=%h expected 1/00001008", busy, mem_addr);
    end
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    n_tests++;
    if (k != 4 || rsp_err !== 2'b00 || rsp_rdata !== exp_load(32'h1008, 2'd2, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d err=%b rdata=%h expected 4/00/%h", k, rsp_err, rsp_rdata,
               exp_load(32'h1008, 2'd2, 1'b0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random;
    logic        we, uns, mis;
    logic [1:0]  sz;
    logic [31:0] a, wd, erd;
    int          hold, lat;
    res_t r;
    for (int n = 0; n < 40; n++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 1) != 0 ? 32'h2000 : 32'h1000) + 32'($urandom_range(0, 60));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      stall_len = $urandom_range(1, 4);
      mis  = is_mis(a, sz);
      erd  = (mis || we) ? 32'h0 : exp_load(a, sz, uns);
      lat  = stall_len + 2;
      run_txn(we, a, wd, sz, uns, hold, r);
      n_tests++;
      if (!r.acc || r.err !== (mis ? 2'b01 : 2'b00) || (mis ? r.k > 1 : r.k != lat)) begin
        n_fail++;
        $display("FAIL rnd%0d_rsp: got acc=%0d err=%b lat=%0d expected err=%b lat=%0d", n, r.acc, r.err, r.k,
                 mis ? 2'b01 : 2'b00, mis ? 1 : lat);
      end
      n_tests++;
      if (r.rdata !== erd) begin
        n_fail++;
        $display("FAIL rnd%0d_rdata: got %h expected %h (a=%h sz=%0d u=%0d we=%0d)", n, r.rdata, erd, a, sz, uns, we);
      end
      n_tests++;
      if (r.maddr !== a || r.mwdata !== wd || (sz != 2'd3 && r.mask !== exp_mask(we, sz, uns))) begin
        n_fail++;
        $display("FAIL rnd%0d_bus: got addr=%h wdata=%h mask=%b expected %h/%h/%b", n, r.maddr, r.mwdata, r.mask,
                 a, wd, exp_mask(we, sz, uns));
      end
      n_tests++;
      if (r.nrd != ((!mis && !we) ? 1 : 0) || r.nwr != ((!mis && we) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_strobe: got reads=%0d writes=%0d expected %0d/%0d", n, r.nrd, r.nwr,
                 (!mis && !we) ? 1 : 0, (!mis && we) ? 1 : 0);
      end
      n_tests++;
      if (!r.stable || r.vafter !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_hold: got stable=%0d valid_after=%b expected 1/0", n, r.stable, r.vafter);
      end
      if (!mis && we) ref_store(a, wd, sz);
    end
    stall_len = 2;
  endtask

  initial begin
    for (int i = 0; i < 68; i++) begin
      dm_b[32'h1000 + i]  = 8'($urandom);
      dm_b[32'h2000 + i]  = 8'($urandom);
      ref_b[32'h1000 + i] = dm_b[32'h1000 + i];
      ref_b[32'h2000 + i] = dm_b[32'h2000 + i];
    end
    dm_b[32'h1003] = 8'h80; dm_b[32'h1004] = 8'hEF; dm_b[32'h1005] = 8'hBE;
    dm_b[32'h1006] = 8'hAD; dm_b[32'h1007] = 8'hDE;
    ref_b[32'h1003] = 8'h80; ref_b[32'h1004] = 8'hEF; ref_b[32'h1005] = 8'hBE;
    ref_b[32'h1006] = 8'hAD; ref_b[32'h1007] = 8'hDE;

    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_resp_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected summary before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
